// File: rtl/tile_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tile_buffer_ram
//  Description : Simple dual-port per-tile colour/depth buffer.
//                - One write port with per-lane write mask.
//                - One read port with a read latency of 1 or 2 cycles.
//                - Built-in clear engine that sweeps the whole memory with a
//                  latched clear value at one word per clock.
//  Ports       : clk, reset (async, active-high)
//                writeData/writeCs/write/writeAddr/writeMask : write port
//                readCs/readAddr -> readData/readValid        : read port
//                clearColor/clearStart -> clearBusy/clearDone : clear engine
//  Options     : `define TILE_BUFFER_RAM_BYPASS_EN enables write-first
//                forwarding when a read and a write hit the same address in
//                the same cycle. Default (undefined) is read-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_buffer_ram #(
  parameter  int MEM_SIZE_BYTES     = 14,
  parameter  int MEM_WIDTH          = 32,
  parameter  int WRITE_STROBE_WIDTH = 8,
  parameter  int READ_LATENCY       = 1,
  localparam int MEM_SIZE           = MEM_SIZE_BYTES - $clog2(MEM_WIDTH / 8),
  localparam int WRITE_MASK_SIZE    = MEM_WIDTH / WRITE_STROBE_WIDTH,
  localparam int DEPTH              = 1 << MEM_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MEM_WIDTH-1:0]       writeData,
  input  logic                       writeCs,
  input  logic                       write,
  input  logic [MEM_SIZE-1:0]        writeAddr,
  input  logic [WRITE_MASK_SIZE-1:0] writeMask,
  input  logic                       readCs,
  input  logic [MEM_SIZE-1:0]        readAddr,
  output logic [MEM_WIDTH-1:0]       readData,
  output logic                       readValid,
  input  logic [MEM_WIDTH-1:0]       clearColor,
  input  logic                       clearStart,
  output logic                       clearBusy,
  output logic                       clearDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam logic [MEM_SIZE-1:0] LAST_ADDR = {MEM_SIZE{1'b1}};

  clr_state_t                 state_q;
  logic [MEM_SIZE-1:0]        cnt_q;
  logic [MEM_WIDTH-1:0]       color_q;
  logic                       busy_q;
  logic                       done_q;

  logic                       wr_en;
  logic [MEM_SIZE-1:0]        wr_addr;
  logic [MEM_WIDTH-1:0]       wr_data;
  logic [WRITE_MASK_SIZE-1:0] wr_mask;

  logic [MEM_WIDTH-1:0]       mem_q [DEPTH];
  logic [MEM_WIDTH-1:0]       rd_word_d;
  logic [MEM_WIDTH-1:0]       rd1_data_q;
  logic                       rd1_valid_q;

  // --------------------------------------------------------------------------
  // Clear engine. clearBusy covers both CLEAR and DONE so that external writes
  // stay blocked until the engine is back in IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clearStart) begin
            color_q <= clearColor;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          // Counter stops on the last address instead of wrapping.
          if (cnt_q == LAST_ADDR) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign clearBusy = busy_q;
  assign clearDone = done_q;

  // --------------------------------------------------------------------------
  // Single physical write port shared by the clear engine and the pixel
  // pipeline. The sweep owns the port; external writes are dropped while busy.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = writeAddr;
    wr_data = writeData;
    wr_mask = writeMask;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = color_q;
      wr_mask = '1;
    end else if (writeCs && write && !busy_q) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_addr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]
            <= wr_data[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read word selection. Without forwarding the array read sees the contents
  // before this cycle's write (read-first).
  // --------------------------------------------------------------------------
  always_comb begin
    rd_word_d = mem_q[readAddr];
`ifdef TILE_BUFFER_RAM_BYPASS_EN
    // Write-first: merge the lanes being written this cycle.
    if (wr_en && (wr_addr == readAddr)) begin
      for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
        if (wr_mask[i]) begin
          rd_word_d[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]
            = wr_data[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        end
      end
    end
`endif
  end

  // First read stage; data holds when no read is requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
    end else begin
      rd1_valid_q <= readCs;
      if (readCs) begin
        rd1_data_q <= rd_word_d;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [MEM_WIDTH-1:0] rd2_data_q;
      logic                 rd2_valid_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd2_data_q  <= '0;
          rd2_valid_q <= 1'b0;
        end else begin
          rd2_valid_q <= rd1_valid_q;
          if (rd1_valid_q) begin
            rd2_data_q <= rd1_data_q;
          end
        end
      end

      assign readData  = rd2_data_q;
      assign readValid = rd2_valid_q;
    end else begin : g_lat1
      assign readData  = rd1_data_q;
      assign readValid = rd1_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tile_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_buffer_ram
//  Description : Self-checking bench for tile_buffer_ram. Two instances share
//                all inputs, one with read latency 1 and one with latency 2.
//                Expected read responses are queued with their due cycle and
//                popped by per-instance monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_buffer_ram;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writeData = '0;
  logic        writeCs = 1'b0;
  logic        write = 1'b0;
  logic [11:0] writeAddr = '0;
  logic [3:0]  writeMask = '0;
  logic        readCs = 1'b0;
  logic [11:0] readAddr = '0;
  logic [31:0] clearColor = '0;
  logic        clearStart = 1'b0;

  logic [31:0] rdA, rdB;
  logic        vA, vB, busyA, busyB, doneA, doneB;

  tile_buffer_ram #(.READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .writeData(writeData), .writeCs(writeCs), .write(write),
    .writeAddr(writeAddr), .writeMask(writeMask),
    .readCs(readCs), .readAddr(readAddr),
    .readData(rdA), .readValid(vA),
    .clearColor(clearColor), .clearStart(clearStart),
    .clearBusy(busyA), .clearDone(doneA)
  );

  tile_buffer_ram #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .writeData(writeData), .writeCs(writeCs), .write(write),
    .writeAddr(writeAddr), .writeMask(writeMask),
    .readCs(readCs), .readAddr(readAddr),
    .readData(rdB), .readValid(vB),
    .clearColor(clearColor), .clearStart(clearStart),
    .clearBusy(busyB), .clearDone(doneB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected response for a read issued before the coming edge.
  task automatic push_rd(input logic [31:0] e);
    qa.push_back({e, 32'(cyc + 1)});
    qb.push_back({e, 32'(cyc + 2)});
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    readCs   = 1'b1;
    readAddr = a;
    push_rd(e);
    tick();
    readCs = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    writeCs   = 1'b1;
    write     = 1'b1;
    writeAddr = a;
    writeData = d;
    writeMask = m;
    tick();
    writeCs = 1'b0;
    write   = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  // Monitor for the latency-1 instance.
  always @(negedge clk) begin
    if (!reset) begin
      while (qa.size() > 0 && qa[0].due < 32'(cyc)) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdA missing: no readValid, expected data %h at cycle %0d (now %0d)",
                 qa[0].d, qa[0].due, cyc);
        ea = qa.pop_front();
      end
      if (vA) begin
        n_chk++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL rdA unexpected readValid: data %h at cycle %0d, none expected", rdA, cyc);
        end else begin
          ea = qa.pop_front();
          if (rdA !== ea.d || 32'(cyc) !== ea.due) begin
            n_fail++;
            $display("FAIL rdA data: got %h at cycle %0d expected %h at cycle %0d",
                     rdA, cyc, ea.d, ea.due);
          end
        end
      end
    end
  end

  // Monitor for the latency-2 instance.
  always @(negedge clk) begin
    if (!reset) begin
      while (qb.size() > 0 && qb[0].due < 32'(cyc)) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdB missing: no readValid, expected data %h at cycle %0d (now %0d)",
                 qb[0].d, qb[0].due, cyc);
        eb = qb.pop_front();
      end
      if (vB) begin
        n_chk++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL rdB unexpected readValid: data %h at cycle %0d, none expected", rdB, cyc);
        end else begin
          eb = qb.pop_front();
          if (rdB !== eb.d || 32'(cyc) !== eb.due) begin
            n_fail++;
            $display("FAIL rdB data: got %h at cycle %0d expected %h at cycle %0d",
                     rdB, cyc, eb.d, eb.due);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   busy_n;
    int   done_n;
    int   done_at;
    logic ended;
    logic stray;

    // Reset state.
    repeat (3) tick();
    chk("reset rdA", rdA, 32'h0);
    chk("reset vA", {31'b0, vA}, 32'h0);
    chk("reset busyA", {31'b0, busyA}, 32'h0);
    chk("reset doneA", {31'b0, doneA}, 32'h0);
    chk("reset rdB", rdB, 32'h0);
    chk("reset vB", {31'b0, vB}, 32'h0);
    chk("reset busyB", {31'b0, busyB}, 32'h0);
    chk("reset doneB", {31'b0, doneB}, 32'h0);
    reset = 1'b0;
    tick();

    // Lane-masked writes.
    wr(12'd5, 32'hDEADBEEF, 4'b1111);
    wr(12'd5, 32'h11223344, 4'b0101);
    rd(12'd5, 32'hDE22BE44);
    wr(12'd5, 32'hFFFFFFFF, 4'b0000);
    // writeCs without write, and write without writeCs: no change.
    writeCs = 1'b1; write = 1'b0; writeAddr = 12'd5; writeData = 32'h0; writeMask = 4'hF;
    tick();
    writeCs = 1'b0; write = 1'b1;
    tick();
    write = 1'b0;
    rd(12'd5, 32'hDE22BE44);
    drain();
    // Output holds without readCs.
    chk("hold rdA", rdA, 32'hDE22BE44);
    chk("hold rdB", rdB, 32'hDE22BE44);
    chk("hold vA", {31'b0, vA}, 32'h0);

    // Same-cycle read and write to one address.
    wr(12'd7, 32'h55555555, 4'b1111);
    writeCs = 1'b1; write = 1'b1; writeAddr = 12'd7; writeData = 32'hAAAAAAAA; writeMask = 4'b1111;
    readCs = 1'b1; readAddr = 12'd7;
`ifdef TILE_BUFFER_RAM_BYPASS_EN
    push_rd(32'hAAAAAAAA);
`else
    push_rd(32'h55555555);
`endif
    tick();
    writeCs = 1'b0; write = 1'b0; readCs = 1'b0;
    rd(12'd7, 32'hAAAAAAAA);
    wr(12'd7, 32'h55555555, 4'b1111);
    writeCs = 1'b1; write = 1'b1; writeAddr = 12'd7; writeData = 32'hAAAAAAAA; writeMask = 4'b0011;
    readCs = 1'b1; readAddr = 12'd7;
`ifdef TILE_BUFFER_RAM_BYPASS_EN
    push_rd(32'h5555AAAA);
`else
    push_rd(32'h55555555);
`endif
    tick();
    writeCs = 1'b0; write = 1'b0; readCs = 1'b0;
    rd(12'd7, 32'h5555AAAA);
    drain();

    // Streaming reads, one per cycle.
    for (int i = 0; i < 16; i++) wr(12'(i), 32'hC0DE0000 | 32'(i), 4'b1111);
    for (int i = 0; i < 16; i++) begin
      readCs   = 1'b1;
      readAddr = 12'(i);
      push_rd(32'hC0DE0000 | 32'(i));
      tick();
    end
    readCs = 1'b0;
    drain();

    // Reset in the middle of a sweep (counter at 100).
    wr(12'd50, 32'h50505050, 4'b1111);
    wr(12'd200, 32'h02000200, 4'b1111);
    clearColor = 32'h00FF00FF;
    clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    chk("sweep busyA", {31'b0, busyA}, 32'h1);
    repeat (100) tick();
    reset = 1'b1;
    #1;
    chk("abort busyA", {31'b0, busyA}, 32'h0);
    chk("abort busyB", {31'b0, busyB}, 32'h0);
    chk("abort vA", {31'b0, vA}, 32'h0);
    chk("abort rdA", rdA, 32'h0);
    tick();
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (doneA || busyA || doneB || busyB) stray = 1'b1;
      tick();
    end
    chk("abort no done", {31'b0, stray}, 32'h0);
    rd(12'd50, 32'h00FF00FF);
    rd(12'd99, 32'h00FF00FF);
    rd(12'd200, 32'h02000200);
    drain();

    // Full sweep; a write in the start cycle is overwritten.
    clearColor = 32'h00FF00FF;
    clearStart = 1'b1;
    writeCs = 1'b1; write = 1'b1; writeAddr = 12'd10; writeData = 32'h0000BEEF; writeMask = 4'hF;
    tick();
    clearStart = 1'b0; writeCs = 1'b0; write = 1'b0;
    clearColor = 32'h11111111;
    busy_n = 0; done_n = 0; done_at = -1; ended = 1'b0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      if (!busyA) begin
        ended = 1'b1;
        break;
      end
      busy_n++;
      if (doneA) begin
        done_n++;
        done_at = busy_n;
      end
      writeCs    = (i == 5);
      write      = (i == 5);
      writeAddr  = 12'd3;
      writeData  = 32'h12345678;
      writeMask  = 4'hF;
      clearStart = (i == 7);
      if (i == 10) begin
        readCs   = 1'b1;
        readAddr = 12'd3;
        push_rd(32'h00FF00FF);
      end else begin
        readCs = 1'b0;
      end
      tick();
    end
    writeCs = 1'b0; write = 1'b0; clearStart = 1'b0; readCs = 1'b0;
    chk("sweep ended", {31'b0, ended}, 32'h1);
    chk("busy cycles", 32'(busy_n), 32'(DEPTH + 1));
    chk("done pulses", 32'(done_n), 32'h1);
    chk("done position", 32'(done_at), 32'(DEPTH + 1));
    chk("done low after", {31'b0, doneA}, 32'h0);
    rd(12'd0, 32'h00FF00FF);
    rd(12'(DEPTH - 1), 32'h00FF00FF);
    rd(12'd3, 32'h00FF00FF);
    rd(12'd10, 32'h00FF00FF);
    rd(12'd200, 32'h00FF00FF);
    drain();

    chk("queue A empty", 32'(qa.size()), 32'h0);
    chk("queue B empty", 32'(qb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
